npu_inst_fetch_decode: RTL and testbench

- Instruction fetch and decode stage directly upstream of the NPU scheduler.
- On a fetch request pulse with a PC, reads one 32-bit instruction word from the synchronous instruction SRAM and decodes it into opcode, jump target, DMA-mode flags and an error flag.
- Presents the result to the scheduler as a single-cycle valid pulse, with fields held stable until the next fetch.
- Aborts cleanly on flush (start/stop).

---
 rtl/npu_inst_fetch_decode.sv | 65 ++++++
 tb/tb_npu_inst_fetch_decode.sv | 133 +++++++++++++
 2 files changed

// File: rtl/npu_inst_fetch_decode.sv
// npu_inst_fetch_decode: fetches one instruction word from the synchronous SRAM and decodes it for the scheduler.
module npu_inst_fetch_decode #(
  parameter int INST_AW    = 12,
  parameter int INST_DEPTH = 4096,
  parameter int RD_LATENCY = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_fetch_en,
  input  logic [INST_AW-1:0] i_pc,
  input  logic               i_flush,
  output logic               o_mem_rd_en,
  output logic [INST_AW-1:0] o_mem_addr,
  input  logic [31:0]        i_mem_rdata,
  output logic               o_inst_valid,
  output logic [4:0]         o_opcode,
  output logic               o_be_noblock,
  output logic               o_wait_last_noblock_dma,
  output logic [INST_AW-1:0] o_jump_pc,
  output logic [31:0]        o_inst,
  output logic               o_err_inst,
  output logic               o_busy,
  output logic               o_fetch_overrun
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;
  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);
  logic [1:0] state, state_nxt, lat_cnt;
  logic op_err, jump_err;
  always_comb begin
    state_nxt = i_flush          ? IDLE :
                (state == IDLE)  ? (i_fetch_en ? REQ : IDLE) :
                (state == REQ)   ? WAIT :
                (state == WAIT)  ? (lat_cnt == 2'd0 ? OUT : WAIT) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      lat_cnt         <= 2'd0;
      o_mem_addr      <= '0;
      o_inst          <= '0;
      o_fetch_overrun <= 1'b0;
    end else begin
      if (i_fetch_en && state != IDLE) o_fetch_overrun <= 1'b1;
      if (state == IDLE && i_fetch_en && !i_flush) o_mem_addr <= i_pc;
      if (state == WAIT && lat_cnt == 2'd0 && !i_flush) o_inst <= i_mem_rdata;
      lat_cnt <= (state == REQ) ? LAT_INIT : (state == WAIT) ? lat_cnt - 2'd1 : lat_cnt;
      state   <= state_nxt;
    end
  end
  // a flush or reset in the OUT cycle swallows the pulse
  assign o_inst_valid            = (state == OUT) && !i_flush && !i_rst;
  assign o_mem_rd_en             = (state == REQ);
  assign o_busy                  = (state != IDLE);
  assign o_opcode                = o_inst[31:27];
  assign o_be_noblock            = o_inst[26];
  assign o_wait_last_noblock_dma = o_inst[25];
  assign o_jump_pc               = o_inst[INST_AW-1:0];
  assign op_err   = !(o_opcode inside {5'b00000, 5'b01010, 5'b01011, 5'b01101,
                                       5'b10010, 5'b11100, 5'b00110, 5'b11111});
  assign jump_err = (o_opcode == 5'b11100) && ({20'd0, o_inst[11:0]} >= 32'(INST_DEPTH));
  assign o_err_inst = o_inst_valid && (op_err || jump_err);
endmodule

// File: tb/tb_npu_inst_fetch_decode.sv
// tb_npu_inst_fetch_decode: randomized fetch/flush/reset traffic on three configurations against a transaction-timing model.
module tb_npu_inst_fetch_decode;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] fe, fl, rd_en, valid, be, wl, err, busy, ovr;
  logic [11:0] pc [3];
  logic [11:0] addr [3];
  logic [11:0] jpc [3];
  logic [4:0]  opc [3];
  logic [31:0] inst [3];
  logic [31:0] rdata [3];
  logic [31:0] mem [4096];
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  genvar g;
  for (g = 0; g < 3; g++) begin : gi
    localparam int L = (g == 2) ? 3 : 1;
    localparam int D = (g == 1) ? 256 : 4096;
    logic [31:0] s [3];
    npu_inst_fetch_decode #(.INST_AW(12), .INST_DEPTH(D), .RD_LATENCY(L)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_fetch_en(fe[g]), .i_pc(pc[g]), .i_flush(fl[g]),
      .o_mem_rd_en(rd_en[g]), .o_mem_addr(addr[g]), .i_mem_rdata(rdata[g]),
      .o_inst_valid(valid[g]), .o_opcode(opc[g]), .o_be_noblock(be[g]),
      .o_wait_last_noblock_dma(wl[g]), .o_jump_pc(jpc[g]), .o_inst(inst[g]),
      .o_err_inst(err[g]), .o_busy(busy[g]), .o_fetch_overrun(ovr[g]));
    // SRAM: data appears exactly L cycles after the read enable, garbage otherwise
    always @(posedge clk) begin
      s[0] <= rd_en[g] ? mem[addr[g]] : 32'hdead_beef;
      s[1] <= s[0];
      s[2] <= s[1];
    end
    assign rdata[g] = s[L-1];
  end
  function automatic int lat(input int k);
    return (k == 2) ? 3 : 1;
  endfunction
  function automatic int depth(input int k);
    return (k == 1) ? 256 : 4096;
  endfunction
  function automatic bit word_err(input logic [31:0] w, input int d);
    int op;
    int tgt;
    op  = int'(w >> 27);
    tgt = int'(w & 32'hfff);
    if (!(op inside {0, 10, 11, 13, 18, 28, 6, 31})) return 1'b1;
    return (op == 28) && (tgt >= d);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  int acc [3];
  logic [11:0] pcl [3];
  logic [31:0] word [3];
  bit mo [3];
  initial begin
    logic [4:0] ops [8];
    ops = '{5'b00000, 5'b01010, 5'b01011, 5'b01101, 5'b10010, 5'b11100, 5'b00110, 5'b11111};
    for (int i = 0; i < 4096; i++) begin
      int r;
      r = $urandom_range(0, 9);
      mem[i] = (r < 6) ? {ops[$urandom_range(0, 7)], 27'($urandom)} :
               (r < 8) ? {5'b11100, 15'($urandom), 12'($urandom)} : 32'($urandom);
    end
    mem[5] = 32'h9400_0000;
    mem[0] = 32'hE000_0123;
    mem[7] = 32'h0800_0000;
    rst = 1'b1;
    fe = '0;
    fl = '0;
    for (int k = 0; k < 3; k++) begin
      pc[k] = '0;
      acc[k] = -1;
      pcl[k] = '0;
      word[k] = '0;
      mo[k] = 1'b0;
    end
    @(posedge clk);
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      bit eb [3];
      @(negedge clk);
      rst = (cyc < 3) || ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 3; k++) begin
        int sel;
        eb[k] = (acc[k] >= 0) && (cyc >= acc[k] + 1) && (cyc <= acc[k] + 2 + lat(k));
        fe[k] = eb[k] ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 4);
        fl[k] = ($urandom_range(0, 29) == 0);
        sel = $urandom_range(0, 5);
        pc[k] = (sel == 0) ? 12'd0 : (sel == 1) ? 12'd5 : (sel == 2) ? 12'd7 : 12'($urandom);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        bit ev;
        ev = eb[k] && (cyc == acc[k] + 2 + lat(k)) && !fl[k] && !rst;
        check($sformatf("valid[%0d]@%0d", k, cyc), valid[k], ev);
        check($sformatf("err[%0d]@%0d", k, cyc), err[k], ev && word_err(word[k], depth(k)));
        check($sformatf("rd_en[%0d]@%0d", k, cyc), rd_en[k], eb[k] && (cyc == acc[k] + 1));
        check($sformatf("addr[%0d]@%0d", k, cyc), addr[k], pcl[k]);
        check($sformatf("busy[%0d]@%0d", k, cyc), busy[k], eb[k]);
        check($sformatf("overrun[%0d]@%0d", k, cyc), ovr[k], mo[k]);
        check($sformatf("inst[%0d]@%0d", k, cyc), inst[k], word[k]);
        check($sformatf("opcode[%0d]@%0d", k, cyc), opc[k], word[k] >> 27);
        check($sformatf("be_noblock[%0d]@%0d", k, cyc), be[k], (word[k] >> 26) & 1);
        check($sformatf("wait_last[%0d]@%0d", k, cyc), wl[k], (word[k] >> 25) & 1);
        check($sformatf("jump_pc[%0d]@%0d", k, cyc), jpc[k], word[k] & 32'hfff);
      end
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          acc[k] = -1;
          pcl[k] = '0;
          word[k] = '0;
          mo[k] = 1'b0;
        end else begin
          if (fe[k] && eb[k]) mo[k] = 1'b1;
          if (eb[k] && (cyc == acc[k] + 1 + lat(k)) && !fl[k]) word[k] = mem[pcl[k]];
          if (fl[k]) acc[k] = -1;
          else if (eb[k]) begin
            if (cyc == acc[k] + 2 + lat(k)) acc[k] = -1;
          end else if (fe[k]) begin
            acc[k] = cyc;
            pcl[k] = pc[k];
          end
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
